// File: rtl/mem_responder_if.sv
// Datapath/cache bus between a pipelined datapath (master) and a memory responder (slave).
// Also carries the halt line and the bench preload port.
interface mem_responder_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        dhit;
   logic [31:0] dmemload;
   logic        halt;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        err;

   modport master (
      output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
      output halt, ld_en, ld_addr, ld_data,
      input  ihit, imemload, dhit, dmemload, err
   );

   modport slave (
      input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  halt, ld_en, ld_addr, ld_data,
      output ihit, imemload, dhit, dmemload, err
   );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the datapath: data accesses win over fetches,
// one request in service at a time, hits returned combinationally once the wait expires.
module mem_responder #(
   parameter int unsigned IDX_W   = 10,
   parameter int unsigned LATENCY = 2
) (
   input logic            CLK,
   input logic            nRST,
   mem_responder_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StBusyD, StBusyI, StHalted} state_e;

   localparam logic [3:0] CntInit = 4'(LATENCY - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wr_q, wr_d;
   logic [31:0]      store_q, store_d;
   logic             err_q, err_d;
   logic             mem_we;
   logic [31:0]      mem_q [2**IDX_W];

   logic             d_req;
   logic [IDX_W-1:0] d_idx, i_idx, ld_idx;
   logic             unused_addr;

   assign d_req  = bus_io.dmemREN | bus_io.dmemWEN;
   assign d_idx  = bus_io.dmemaddr[IDX_W+1:2];
   assign i_idx  = bus_io.imemaddr[IDX_W+1:2];
   assign ld_idx = bus_io.ld_addr[IDX_W+1:2];
   // Byte-offset and above-index address bits alias by design.
   assign unused_addr = ^{bus_io.dmemaddr[31:IDX_W+2], bus_io.dmemaddr[1:0],
                          bus_io.imemaddr[31:IDX_W+2], bus_io.imemaddr[1:0],
                          bus_io.ld_addr[31:IDX_W+2], bus_io.ld_addr[1:0]};

   assign bus_io.err = err_q;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      idx_d           = idx_q;
      wr_d            = wr_q;
      store_d         = store_q;
      err_d           = err_q;
      mem_we          = 1'b0;
      bus_io.ihit     = 1'b0;
      bus_io.dhit     = 1'b0;
      bus_io.imemload = '0;
      bus_io.dmemload = '0;
      unique case (state_q)
         StIdle: begin
            if (bus_io.halt) begin
               state_d = StHalted;
            end else if (d_req) begin
               state_d = StBusyD;
               idx_d   = d_idx;
               wr_d    = bus_io.dmemWEN;
               store_d = bus_io.dmemstore;
               cnt_d   = CntInit;
               err_d   = err_q | (bus_io.dmemREN & bus_io.dmemWEN);
            end else if (bus_io.imemREN) begin
               state_d = StBusyI;
               idx_d   = i_idx;
               wr_d    = 1'b0;
               store_d = bus_io.dmemstore;
               cnt_d   = CntInit;
            end
         end
         StBusyD: begin
            if (d_req && cnt_q == '0) begin
               bus_io.dhit = 1'b1;
               if (wr_q) mem_we = 1'b1;
               else      bus_io.dmemload = mem_q[idx_q];
            end
            // A dropped request line is a pipeline flush: abandon without a hit.
            if (bus_io.halt)                  state_d = StHalted;
            else if (!d_req || cnt_q == '0)   state_d = StIdle;
            else                              cnt_d   = cnt_q - 4'd1;
         end
         StBusyI: begin
            if (bus_io.imemREN && cnt_q == '0) begin
               bus_io.ihit     = 1'b1;
               bus_io.imemload = mem_q[idx_q];
            end
            if (bus_io.halt)                         state_d = StHalted;
            else if (!bus_io.imemREN || cnt_q == '0) state_d = StIdle;
            else                                     cnt_d   = cnt_q - 4'd1;
         end
         StHalted: begin
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         store_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         store_q <= store_d;
         err_q   <= err_d;
      end
   end

   // Memory is not reset; a hit write overrides a same-cycle preload to the same word.
   always_ff @(posedge CLK) begin
      if (bus_io.ld_en) mem_q[ld_idx] <= bus_io.ld_data;
      if (mem_we)       mem_q[idx_q]  <= store_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed literal scenarios plus a randomized requester,
// all checked every cycle against a cycle-count based transaction model.
module tb_mem_responder;
   localparam int unsigned IdxW = 10;
   localparam int unsigned Lat  = 2;

   logic CLK;
   logic nRST;
   mem_responder_if bus ();

   mem_responder #(.IDX_W(IdxW), .LATENCY(Lat)) dut (
      .CLK    (CLK),
      .nRST   (nRST),
      .bus_io (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: one service at a time, hit due Lat cycles after the accepting cycle.
   logic [31:0] m_mem [int];
   int          m_kind;  // 0 none, 1 data, 2 instruction
   int          m_acc;
   int          m_idx;
   logic        m_wr, m_halted, m_err, line, hit_wr, e_ih, e_dh;
   logic [31:0] m_data, e_il, e_dl;

   logic d_act, i_act, dh, ih, got;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a[IdxW+1:2]);
   endfunction

   function automatic logic [31:0] mrd(input int i);
      if (m_mem.exists(i)) return m_mem[i];
      return 32'h0;
   endfunction

   function automatic logic [31:0] mk_addr(input int k);
      logic [31:0] a;
      a        = $urandom;
      a[11:2]  = 10'h300 + 10'(k);
      return a;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_ihit"}, 32'(bus.ihit), 32'h0);
      chk({tag, "_dhit"}, 32'(bus.dhit), 32'h0);
      chk({tag, "_imemload"}, bus.imemload, 32'h0);
      chk({tag, "_dmemload"}, bus.dmemload, 32'h0);
   endtask

   always @(negedge CLK) begin
      cyc++;
      if (!nRST) begin
         chk_zero("rst");
         chk("rst_err", 32'(bus.err), 32'h0);
         m_kind = 0; m_halted = 1'b0; m_err = 1'b0;
         if (bus.ld_en === 1'b1) m_mem[widx(bus.ld_addr)] = bus.ld_data;
      end else begin
         e_ih = 1'b0; e_dh = 1'b0; e_il = '0; e_dl = '0; hit_wr = 1'b0;
         line = (m_kind == 1) ? (bus.dmemREN | bus.dmemWEN) : bus.imemREN;
         if (!m_halted && m_kind != 0 && line && cyc == m_acc + int'(Lat)) begin
            if (m_kind == 1) begin
               e_dh = 1'b1;
               if (m_wr) hit_wr = 1'b1;
               else      e_dl   = mrd(m_idx);
            end else begin
               e_ih = 1'b1;
               e_il = mrd(m_idx);
            end
         end
         chk("ihit", 32'(bus.ihit), 32'(e_ih));
         chk("dhit", 32'(bus.dhit), 32'(e_dh));
         chk("imemload", bus.imemload, e_il);
         chk("dmemload", bus.dmemload, e_dl);
         chk("err", 32'(bus.err), 32'(m_err));
         if (bus.ld_en) m_mem[widx(bus.ld_addr)] = bus.ld_data;
         if (hit_wr)    m_mem[m_idx] = m_data;
         if (m_halted) begin
         end else if (bus.halt) begin
            m_halted = 1'b1; m_kind = 0;
         end else if (m_kind != 0) begin
            if (!line || e_ih || e_dh) m_kind = 0;
         end else if (bus.dmemREN | bus.dmemWEN) begin
            m_kind = 1; m_acc = cyc; m_idx = widx(bus.dmemaddr);
            m_wr = bus.dmemWEN; m_data = bus.dmemstore;
            m_err = m_err | (bus.dmemREN & bus.dmemWEN);
         end else if (bus.imemREN) begin
            m_kind = 2; m_acc = cyc; m_idx = widx(bus.imemaddr); m_wr = 1'b0;
         end
      end
   end

   task automatic clr_inputs();
      bus.imemREN = 0; bus.imemaddr = '0; bus.dmemREN = 0; bus.dmemWEN = 0;
      bus.dmemaddr = '0; bus.dmemstore = '0; bus.halt = 0;
      bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0;
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      bus.ld_en = 1; bus.ld_addr = a; bus.ld_data = d;
      step();
      bus.ld_en = 0;
   endtask

   task automatic rst_pulse(input string tag);
      #1 nRST = 0;
      #1 chk_zero(tag);
      chk({tag, "_err"}, 32'(bus.err), 32'h0);
      clr_inputs();
      @(negedge CLK); #2 nRST = 1;
      step();
   endtask

   task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
      bus.dmemREN = 1; bus.dmemWEN = 0; bus.dmemaddr = a;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge CLK);
         if (bus.dhit) begin
            got = 1'b1;
            chk(nm, bus.dmemload, exp);
         end
         step();
      end
      bus.dmemREN = 0;
      if (!got) begin
         total++; bad++;
         $display("FAIL %s: no dhit within 20 cycles, want %h", nm, exp);
      end
   endtask

   task automatic new_d();
      int r;
      r = $urandom_range(0, 31);
      if (r == 0)     begin bus.dmemREN = 1; bus.dmemWEN = 1; end
      else if (r < 14) begin bus.dmemREN = 0; bus.dmemWEN = 1; end
      else            begin bus.dmemREN = 1; bus.dmemWEN = 0; end
      bus.dmemaddr  = mk_addr($urandom_range(0, 15));
      bus.dmemstore = $urandom;
      d_act = 1'b1;
   endtask

   task automatic new_i();
      bus.imemREN  = 1;
      bus.imemaddr = mk_addr($urandom_range(0, 15));
      i_act = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      nRST = 0;
      clr_inputs();
      repeat (2) @(negedge CLK);
      chk_zero("reset");
      chk("reset_err", 32'(bus.err), 32'h0);
      #2 nRST = 1;
      step();

      // Instruction fetch of a preloaded word, hit in cycle 2 only.
      preload(32'h40, 32'hDEADBEEF);
      bus.imemREN = 1; bus.imemaddr = 32'h40;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         chk("t1_ihit", 32'(bus.ihit), (c == 2) ? 32'h1 : 32'h0);
         chk("t1_imemload", bus.imemload, (c == 2) ? 32'hDEADBEEF : 32'h0);
         step();
      end
      bus.imemREN = 0;
      repeat (3) step();

      // Write then read back: hits at cycles 2 and 5.
      bus.dmemWEN = 1; bus.dmemaddr = 32'h80; bus.dmemstore = 32'h12345678;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         chk("t2_dhit", 32'(bus.dhit), (c == 2 || c == 5) ? 32'h1 : 32'h0);
         chk("t2_dmemload", bus.dmemload, (c == 5) ? 32'h12345678 : 32'h0);
         step();
         if (c == 2) begin bus.dmemWEN = 0; bus.dmemREN = 1; end
      end
      bus.dmemREN = 0;
      repeat (2) step();

      // Simultaneous I and D: data first, fetch hit at 2L+1.
      bus.dmemREN = 1; bus.dmemaddr = 32'h80; bus.imemREN = 1; bus.imemaddr = 32'h40;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         chk("t3_dhit", 32'(bus.dhit), (c == 2) ? 32'h1 : 32'h0);
         chk("t3_ihit", 32'(bus.ihit), (c == 5) ? 32'h1 : 32'h0);
         step();
         if (c == 2) bus.dmemREN = 0;
      end
      bus.imemREN = 0;
      repeat (2) step();

      // Flushed write leaves memory untouched.
      preload(32'h100, 32'hCAFEF00D);
      bus.dmemWEN = 1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'h11111111;
      @(negedge CLK); chk("t4_dhit0", 32'(bus.dhit), 32'h0);
      step();
      bus.dmemWEN = 0;
      for (int c = 1; c < 3; c++) begin
         @(negedge CLK); chk("t4_dhit", 32'(bus.dhit), 32'h0);
         step();
      end
      do_read("t4_read", 32'h100, 32'hCAFEF00D);

      // REN and WEN together: sticky err, performed as a write.
      bus.dmemREN = 1; bus.dmemWEN = 1; bus.dmemaddr = 32'h180; bus.dmemstore = 32'h55AA55AA;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         chk("t5_err", 32'(bus.err), (c == 0) ? 32'h0 : 32'h1);
         chk("t5_dhit", 32'(bus.dhit), (c == 2) ? 32'h1 : 32'h0);
         chk("t5_dmemload", bus.dmemload, 32'h0);
         step();
      end
      bus.dmemREN = 0; bus.dmemWEN = 0;
      do_read("t5_read", 32'h180, 32'h55AA55AA);

      // Async reset in the middle of a hit cycle.
      bus.dmemREN = 1; bus.dmemaddr = 32'h180;
      repeat (2) begin @(negedge CLK); step(); end
      chk("t5_prehit", 32'(bus.dhit), 32'h1);
      chk("t5_preload", bus.dmemload, 32'h55AA55AA);
      chk("t5_preerr", 32'(bus.err), 32'h1);
      rst_pulse("t5_async");

      // Halt during an in-flight write freezes everything until reset.
      preload(32'h200, 32'h0BADC0DE);
      bus.dmemWEN = 1; bus.dmemaddr = 32'h200; bus.dmemstore = 32'h77777777;
      @(negedge CLK); step();
      bus.halt = 1; bus.imemREN = 1; bus.imemaddr = 32'h40;
      for (int c = 1; c < 6; c++) begin
         @(negedge CLK); chk_zero("t6_halt");
         step();
      end
      rst_pulse("t6_rst");
      do_read("t6_read", 32'h200, 32'h0BADC0DE);

      // Randomized requester honouring the hold-until-hit obligation.
      for (int k = 0; k < 16; k++) preload(mk_addr(k), $urandom);
      d_act = 1'b0; i_act = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge CLK);
         dh = bus.dhit; ih = bus.ihit;
         step();
         if (d_act && dh) begin
            if ($urandom_range(0, 1) == 0) new_d();
            else begin d_act = 1'b0; bus.dmemREN = 0; bus.dmemWEN = 0; end
         end else if (d_act && $urandom_range(0, 19) == 0) begin
            d_act = 1'b0; bus.dmemREN = 0; bus.dmemWEN = 0;
         end else if (!d_act && $urandom_range(0, 3) == 0) begin
            new_d();
         end
         if (i_act && ih) begin
            if ($urandom_range(0, 1) == 0) new_i();
            else begin i_act = 1'b0; bus.imemREN = 0; end
         end else if (i_act && $urandom_range(0, 19) == 0) begin
            i_act = 1'b0; bus.imemREN = 0;
         end else if (!i_act && $urandom_range(0, 2) == 0) begin
            new_i();
         end
         bus.ld_en   = ($urandom_range(0, 9) == 0);
         bus.ld_addr = mk_addr($urandom_range(0, 15));
         bus.ld_data = $urandom;
      end
      clr_inputs();
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
